adc_capture_ctrl: RTL and testbench

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_pkg.sv | 25 ++
 rtl/adc_serial_shift.sv | 78 +++++++
 rtl/adc_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the serial ADC capture controller.
package adc_capture_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int DEF_SCLK_DIV      = 2;
    localparam int DEF_CONV_CYCLES   = 40;
    localparam int DEF_SAMPLE_PERIOD = 500;
    localparam int DEF_SAMPLE_COUNT  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SHIFT,
        ST_EMIT,
        ST_WAIT
    } state_t;

    // One extra bit so that -32768 maps to +32768 without wrapping.
    function automatic logic [SAMPLE_W:0] sample_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W:0] ext;
        ext = {s[SAMPLE_W-1], s};
        return s[SAMPLE_W-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/adc_serial_shift.sv
// SCLK generator and MSB-first shift register; start launches 16 sclk periods,
// done pulses the cycle after the 16th bit is captured.
module adc_serial_shift
    import adc_capture_pkg::*;
#(
    parameter int SCLK_DIV = DEF_SCLK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sdo,
    output logic                sclk,
    output logic                done,
    output logic [SAMPLE_W-1:0] data
);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic                active_q, active_d;
    logic                sclk_q, sclk_d;
    logic                done_q, done_d;
    logic [DW-1:0]       div_q, div_d;
    logic [4:0]          bits_q, bits_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        done_d   = 1'b0;
        div_d    = div_q;
        bits_d   = bits_q;
        shreg_d  = shreg_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                sclk_d   = 1'b1;
                shreg_d  = {shreg_q[SAMPLE_W-2:0], sdo};
                bits_d   = 5'd1;
                div_d    = DW'(SCLK_DIV - 1);
            end
        end else if (div_q != '0) begin
            div_d = div_q - 1'b1;
        end else if (sclk_q) begin
            sclk_d = 1'b0;
            div_d  = DW'(SCLK_DIV - 1);
            if (bits_q == 5'd16) active_d = 1'b0;
        end else begin
            // sdo is captured on the same edge that raises sclk
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[SAMPLE_W-2:0], sdo};
            bits_d  = bits_q + 5'd1;
            div_d   = DW'(SCLK_DIV - 1);
            if (bits_q == 5'd15) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
            shreg_q  <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            shreg_q  <= shreg_d;
        end
    end

    assign sclk = sclk_q;
    assign done = done_q;
    assign data = shreg_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Serial ADC capture sequencer: convert, shift, emit, pace to SAMPLE_PERIOD.
// ADC_THRESH_TRIG_EN: withhold strobes until |sample| >= threshold latched at arm.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int SCLK_DIV      = DEF_SCLK_DIV,
    parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int SAMPLE_COUNT  = DEF_SAMPLE_COUNT
) (
    input  logic                ADC_I_clk,
    input  logic                I_rst,
    input  logic                I_arm,
    input  logic [SAMPLE_W-1:0] I_threshold,
    output logic                ADC_O_cnv,
    output logic                ADC_O_sclk,
    input  logic                ADC_I_sdo,
    output logic [SAMPLE_W-1:0] ADC_O_data,
    output logic                ADC_O_dataValid,
    output logic                O_busy,
    output logic                O_sampleRdy
);
    // state    | meaning
    // IDLE     | waiting for I_arm
    // CONVERT  | cnv high for CONV_CYCLES clocks
    // SHIFT    | serial readout of 16 bits
    // EMIT     | one-cycle data strobe
    // WAIT     | pad out to SAMPLE_PERIOD, then next conversion or done

    localparam int CW = $clog2(CONV_CYCLES);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    state_t              state_q, state_d;
    logic                cnv_q, cnv_d;
    logic                start_q, start_d;
    logic [CW-1:0]       conv_q, conv_d;
    logic [PW-1:0]       period_q, period_d;
    logic [15:0]         count_q, count_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                rdy_q, rdy_d;
    logic                sh_done;
    logic [SAMPLE_W-1:0] sh_data;
    logic                emit_ok;

`ifdef ADC_THRESH_TRIG_EN
    logic [SAMPLE_W-1:0] thr_q, thr_d;
    logic                trig_q, trig_d;
    assign emit_ok = trig_q || (sample_mag(sh_data) >= {1'b0, thr_q});
`else
    logic unused_thr;
    assign unused_thr = ^I_threshold;
    assign emit_ok    = 1'b1;
`endif

    adc_serial_shift #(.SCLK_DIV(SCLK_DIV)) u_shift (
        .clk   (ADC_I_clk),
        .rst   (I_rst),
        .start (start_q),
        .sdo   (ADC_I_sdo),
        .sclk  (ADC_O_sclk),
        .done  (sh_done),
        .data  (sh_data)
    );

    always_comb begin
        state_d  = state_q;
        cnv_d    = cnv_q;
        start_d  = 1'b0;
        conv_d   = conv_q;
        period_d = (state_q == ST_IDLE) ? '0 : period_q + 1'b1;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        rdy_d    = rdy_q;
`ifdef ADC_THRESH_TRIG_EN
        thr_d    = thr_q;
        trig_d   = trig_q;
`endif
        case (state_q)
            ST_IDLE: if (I_arm) begin
                state_d  = ST_CONVERT;
                cnv_d    = 1'b1;
                conv_d   = CW'(CONV_CYCLES - 1);
                period_d = '0;
                count_d  = '0;
                busy_d   = 1'b1;
                rdy_d    = 1'b0;
`ifdef ADC_THRESH_TRIG_EN
                thr_d    = I_threshold;
                trig_d   = 1'b0;
`endif
            end
            ST_CONVERT: if (conv_q == '0) begin
                state_d = ST_SHIFT;
                cnv_d   = 1'b0;
                start_d = 1'b1;
            end else begin
                conv_d = conv_q - 1'b1;
            end
            ST_SHIFT: if (sh_done) begin
                state_d = ST_EMIT;
                if (emit_ok) begin
                    data_d  = sh_data;
                    valid_d = 1'b1;
                    count_d = count_q + 16'd1;
`ifdef ADC_THRESH_TRIG_EN
                    trig_d  = 1'b1;
`endif
                end
            end
            ST_EMIT: state_d = ST_WAIT;
            ST_WAIT: if (period_q == PW'(SAMPLE_PERIOD - 1)) begin
                period_d = '0;
                if (count_q == 16'(SAMPLE_COUNT)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = ST_CONVERT;
                    cnv_d   = 1'b1;
                    conv_d  = CW'(CONV_CYCLES - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ADC_I_clk) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            cnv_q    <= 1'b0;
            start_q  <= 1'b0;
            conv_q   <= '0;
            period_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef ADC_THRESH_TRIG_EN
            thr_q    <= '0;
            trig_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnv_q    <= cnv_d;
            start_q  <= start_d;
            conv_q   <= conv_d;
            period_q <= period_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
`ifdef ADC_THRESH_TRIG_EN
            thr_q    <= thr_d;
            trig_q   <= trig_d;
`endif
        end
    end

    assign ADC_O_cnv       = cnv_q;
    assign ADC_O_data      = data_q;
    assign ADC_O_dataValid = valid_q;
    assign O_busy          = busy_q;
    assign O_sampleRdy     = rdy_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a behavioural serial ADC driven from the sampling task.
module tb_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [15:0] thr = 16'h0000;
    logic        cnv, sclk, sdo, valid, busy, rdy;
    logic [15:0] data;

    adc_capture_ctrl #(
        .SCLK_DIV(1), .CONV_CYCLES(4), .SAMPLE_PERIOD(40), .SAMPLE_COUNT(4)
    ) dut (
        .ADC_I_clk       (clk),
        .I_rst           (rst),
        .I_arm           (arm),
        .I_threshold     (thr),
        .ADC_O_cnv       (cnv),
        .ADC_O_sclk      (sclk),
        .ADC_I_sdo       (sdo),
        .ADC_O_data      (data),
        .ADC_O_dataValid (valid),
        .O_busy          (busy),
        .O_sampleRdy     (rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        arm;
        logic [20:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] strobe_q[$];
    logic [15:0] adc_seq [8];
    int          adc_len = 1;
    int          adc_idx = 0;
    logic [15:0] adc_word = 16'h0000;
    logic [3:0]  adc_bit = 4'd15;
    logic        prev_cnv = 1'b0, prev_sclk = 1'b0, prev_valid = 1'b0;

    assign sdo = adc_word[adc_bit];

    function automatic logic [20:0] pk(input logic c, s, v, b, r, input logic [15:0] d);
        return {c, s, v, b, r, d};
    endfunction

    function automatic logic [20:0] outs();
        return {cnv, sclk, valid, busy, rdy, data};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // One clock: sample outputs after the falling edge, then update the ADC model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (valid) begin
            n_vec++;
            if (prev_valid) begin
                n_fail++;
                $display("FAIL valid_width: got strobe high two cycles running, required single cycle");
            end
            strobe_q.push_back(data);
        end
        prev_valid = valid;
        if (!busy) begin
            adc_idx = 0;
        end else if (cnv && !prev_cnv) begin
            adc_word = adc_seq[adc_idx % adc_len];
            adc_idx++;
            adc_bit = 4'd15;
        end else if (!sclk && prev_sclk && adc_bit != 4'd0) begin
            adc_bit = adc_bit - 4'd1;
        end
        prev_cnv  = cnv;
        prev_sclk = sclk;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_rdy(input string nm, input int limit);
        int i = 0;
        while (!rdy && i < limit) begin
            tick();
            i++;
        end
        chk({nm, "_done"}, {30'd0, busy, rdy}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[18];
        int          rel;
        int          base;
        logic [15:0] exp_seq[4];

        // k | arm | cnv sclk valid busy rdy data   (k = clocks after arm edge)
        vt[0]  = '{0,   1'b1, pk(1, 0, 0, 1, 0, 16'h0000)};
        vt[1]  = '{3,   1'b0, pk(1, 0, 0, 1, 0, 16'h0000)};
        vt[2]  = '{4,   1'b0, pk(0, 0, 0, 1, 0, 16'h0000)};
        vt[3]  = '{5,   1'b0, pk(0, 1, 0, 1, 0, 16'h0000)};
        vt[4]  = '{6,   1'b0, pk(0, 0, 0, 1, 0, 16'h0000)};
        vt[5]  = '{10,  1'b1, pk(0, 0, 0, 1, 0, 16'h0000)};
        vt[6]  = '{35,  1'b0, pk(0, 1, 0, 1, 0, 16'h0000)};
        vt[7]  = '{36,  1'b0, pk(0, 0, 1, 1, 0, 16'hA5C3)};
        vt[8]  = '{37,  1'b0, pk(0, 0, 0, 1, 0, 16'hA5C3)};
        vt[9]  = '{39,  1'b0, pk(0, 0, 0, 1, 0, 16'hA5C3)};
        vt[10] = '{40,  1'b0, pk(1, 0, 0, 1, 0, 16'hA5C3)};
        vt[11] = '{50,  1'b1, pk(0, 0, 0, 1, 0, 16'hA5C3)};
        vt[12] = '{76,  1'b0, pk(0, 0, 1, 1, 0, 16'hA5C3)};
        vt[13] = '{116, 1'b0, pk(0, 0, 1, 1, 0, 16'hA5C3)};
        vt[14] = '{156, 1'b0, pk(0, 0, 1, 1, 0, 16'hA5C3)};
        vt[15] = '{159, 1'b0, pk(0, 0, 0, 1, 0, 16'hA5C3)};
        vt[16] = '{160, 1'b1, pk(0, 0, 0, 0, 1, 16'hA5C3)};
        vt[17] = '{170, 1'b0, pk(0, 0, 0, 0, 1, 16'hA5C3)};

        adc_seq[0] = 16'hA5C3;
        adc_len = 1;

        tick();
        tick();
        chk("reset_state", 32'(outs()), 32'd0);
        do_arm();
        chk("reset_beats_arm", 32'(outs()), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'(outs()), 32'd0);

        // Main capture timeline, including ignored re-arms and arm at completion
        rel = -1;
        for (int i = 0; i < 18; i++) begin
            while (rel < vt[i].k - 1) begin
                tick();
                rel++;
            end
            arm = vt[i].arm;
            tick();
            arm = 1'b0;
            rel++;
            chk($sformatf("vec_k%0d", vt[i].k), 32'(outs()), 32'(vt[i].exp));
        end
        chk("main_strobe_count", strobe_q.size(), 4);
        for (int i = 0; i < strobe_q.size(); i++)
            chk($sformatf("main_data%0d", i), 32'(strobe_q[i]), 32'h0000A5C3);

        // Reset during the second readout, then a clean re-capture
        base = strobe_q.size();
        do_arm();
        repeat (49) tick();
        chk("sclk_before_reset", 32'(sclk), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_mid_shift", 32'(outs()), 32'd0);
        chk("strobes_before_reset", strobe_q.size() - base, 1);
        base = strobe_q.size();
        do_arm();
        wait_rdy("rearm", 400);
        chk("rearm_strobe_count", strobe_q.size() - base, 4);
        for (int i = base; i < strobe_q.size(); i++)
            chk($sformatf("rearm_data%0d", i - base), 32'(strobe_q[i]), 32'h0000A5C3);

        // Varying samples against a 0x1000 threshold
        adc_seq[0] = 16'h0010; adc_seq[1] = 16'hFFF0; adc_seq[2] = 16'hF000;
        adc_seq[3] = 16'h2000; adc_seq[4] = 16'h0001; adc_seq[5] = 16'h0002;
        adc_seq[6] = 16'h0003;
        adc_len = 7;
        thr = 16'h1000;
`ifdef ADC_THRESH_TRIG_EN
        exp_seq[0] = 16'hF000; exp_seq[1] = 16'h2000;
        exp_seq[2] = 16'h0001; exp_seq[3] = 16'h0002;
`else
        exp_seq[0] = 16'h0010; exp_seq[1] = 16'hFFF0;
        exp_seq[2] = 16'hF000; exp_seq[3] = 16'h2000;
`endif
        base = strobe_q.size();
        do_arm();
        thr = 16'h0000;
        wait_rdy("seq", 1000);
        chk("seq_strobe_count", strobe_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < strobe_q.size())
                chk($sformatf("seq_data%0d", i), 32'(strobe_q[base + i]), 32'(exp_seq[i]));
            else
                chk($sformatf("seq_data%0d", i), 32'hFFFFFFFF, 32'(exp_seq[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
